ccc_clken_reset_seq: RTL

//  - Parametrised successor to the fabric CCC wrapper: consumes the CCC LOCK, debounces it and releases NUM_CH

---
 rtl/ccc_clken_reset_seq_if.sv | 46 ++++
 rtl/ccc_clken_reset_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ccc_clken_reset_seq_if.sv
// ccc_clken_reset_seq_if
//   Handshake/bus bundle between the CCC lock sequencer and its surroundings.
//   Parameters: NUM_CH (channels), DIV_W (per-channel divisor width).
//   Signals:
//     LOCK       CCC PLL lock, asynchronous to the sequencer clock
//     DIVISOR    packed divisors, channel i at [i*DIV_W +: DIV_W]
//     LOSS_CLR   one-cycle pulse clearing LOCK_LOST
//     RST_N_OUT  per-channel active-low reset
//     CLK_EN     per-channel clock-enable pulse
//     READY      all channels released and running
//     LOCK_LOST  sticky lock-loss flag
//     LOSS_COUNT saturating loss counter (only when CCC_LOSS_COUNT_EN is defined)
//   Modports: master drives LOCK/DIVISOR/LOSS_CLR, slave is the sequencer.
interface ccc_clken_reset_seq_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DIV_W  = 8
);
  logic                    LOCK;
  logic [NUM_CH*DIV_W-1:0] DIVISOR;
  logic                    LOSS_CLR;
  logic [NUM_CH-1:0]       RST_N_OUT;
  logic [NUM_CH-1:0]       CLK_EN;
  logic                    READY;
  logic                    LOCK_LOST;
`ifdef CCC_LOSS_COUNT_EN
  logic [7:0]              LOSS_COUNT;

  modport master (
    output LOCK, DIVISOR, LOSS_CLR,
    input  RST_N_OUT, CLK_EN, READY, LOCK_LOST, LOSS_COUNT
  );
  modport slave (
    input  LOCK, DIVISOR, LOSS_CLR,
    output RST_N_OUT, CLK_EN, READY, LOCK_LOST, LOSS_COUNT
  );
`else
  modport master (
    output LOCK, DIVISOR, LOSS_CLR,
    input  RST_N_OUT, CLK_EN, READY, LOCK_LOST
  );
  modport slave (
    input  LOCK, DIVISOR, LOSS_CLR,
    output RST_N_OUT, CLK_EN, READY, LOCK_LOST
  );
`endif
endinterface

// File: rtl/ccc_clken_reset_seq.sv
// ccc_clken_reset_seq
//   Consumes the CCC LOCK, debounces it and releases NUM_CH channel resets in a
//   staggered sequence; generates per-channel clock enables with a runtime
//   divisor (period D+1) in the GL0 domain; detects and flags lock loss.
//   Ports:
//     PCLK      clock (CCC GL0)
//     PRESET_N  asynchronous active-low reset
//     bus       ccc_clken_reset_seq_if.slave (LOCK, DIVISOR, LOSS_CLR in;
//               RST_N_OUT, CLK_EN, READY, LOCK_LOST out)
//   Optional feature macro: CCC_LOSS_COUNT_EN adds bus.LOSS_COUNT, a saturating
//   8-bit count of lock-loss events cleared by LOSS_CLR.
module ccc_clken_reset_seq #(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned STAGGER      = 4
) (
  input  logic                 PCLK,
  input  logic                 PRESET_N,
  ccc_clken_reset_seq_if.slave bus
);

  localparam int unsigned DBC_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned STG_W = $clog2(STAGGER + 1);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYC - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    DEBOUNCE,
    RELEASE,
    RUN,
    LOST
  } state_t;

  state_t            state;
  logic [1:0]        sync_q;
  logic              lock_s;
  logic [DBC_W-1:0]  dbc_cnt;
  logic [STG_W-1:0]  stg_cnt;
  logic [CH_W-1:0]   ch;
  logic [NUM_CH-1:0] rst_q;
  logic [NUM_CH-1:0] rst_nxt;
  logic              ready_q;
  logic              lost_q;
  logic              lost_entry;
  logic [NUM_CH-1:0] clk_en_q;
  logic [DIV_W-1:0]  div_cnt [NUM_CH];
  logic [DIV_W-1:0]  div_q   [NUM_CH];
`ifdef CCC_LOSS_COUNT_EN
  logic [7:0]        loss_cnt;
`endif

  // Two-flop synchroniser: the only consumer of the raw LOCK.
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.LOCK};
    end
  end

  assign lock_s = sync_q[1];

  // Next reset vector is exposed combinationally so the divider can raise its
  // first CLK_EN pulse on the same edge that releases the channel.
  always_comb begin
    lost_entry = 1'b0;
    if ((state == RELEASE || state == RUN) && !lock_s) begin
      lost_entry = 1'b1;
    end
    rst_nxt = rst_q;
    if (lost_entry) begin
      rst_nxt = '0;
    end else if (state == RELEASE && stg_cnt == '0) begin
      rst_nxt[ch] = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state    <= WAIT_LOCK;
      dbc_cnt  <= '0;
      stg_cnt  <= '0;
      ch       <= '0;
      rst_q    <= '0;
      ready_q  <= 1'b0;
      lost_q   <= 1'b0;
`ifdef CCC_LOSS_COUNT_EN
      loss_cnt <= '0;
`endif
    end else begin
      rst_q <= rst_nxt;

      // A loss entry outranks a coincident clear.
      if (lost_entry) begin
        lost_q <= 1'b1;
      end else if (bus.LOSS_CLR) begin
        lost_q <= 1'b0;
      end

`ifdef CCC_LOSS_COUNT_EN
      if (lost_entry) begin
        if (bus.LOSS_CLR) begin
          loss_cnt <= 8'd1;
        end else if (loss_cnt != 8'hFF) begin
          loss_cnt <= loss_cnt + 8'd1;
        end
      end else if (bus.LOSS_CLR) begin
        loss_cnt <= '0;
      end
`endif

      case (state)
        WAIT_LOCK: begin
          ready_q <= 1'b0;
          if (lock_s) begin
            state   <= DEBOUNCE;
            dbc_cnt <= '0;
          end
        end
        DEBOUNCE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (dbc_cnt == DBC_LAST) begin
            state   <= RELEASE;
            ch      <= '0;
            stg_cnt <= '0;
          end else begin
            dbc_cnt <= dbc_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            state <= LOST;
          end else begin
            // Channel ch is released on the stg_cnt==0 edge (see rst_nxt).
            if (stg_cnt == '0 && ch == CH_LAST) begin
              state <= RUN;
            end
            if (stg_cnt == STG_LAST) begin
              stg_cnt <= '0;
              if (ch != CH_LAST) begin
                ch <= ch + 1'b1;
              end
            end else begin
              stg_cnt <= stg_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (!lock_s) begin
            state   <= LOST;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        LOST: begin
          ready_q <= 1'b0;
          state   <= WAIT_LOCK;
        end
        default: begin
          state   <= WAIT_LOCK;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel divider: counts 0..div_q, div_q reloads only at release or
  // wrap so a DIVISOR change never shortens the period in flight.
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      clk_en_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_cnt[i] <= '0;
        div_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!rst_nxt[i]) begin
          div_cnt[i]  <= '0;
          div_q[i]    <= '0;
          clk_en_q[i] <= 1'b0;
        end else if (!rst_q[i] || div_cnt[i] == div_q[i]) begin
          div_cnt[i]  <= '0;
          div_q[i]    <= bus.DIVISOR[i*DIV_W +: DIV_W];
          clk_en_q[i] <= 1'b1;
        end else begin
          div_cnt[i]  <= div_cnt[i] + 1'b1;
          clk_en_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.RST_N_OUT = rst_q;
  assign bus.CLK_EN    = clk_en_q;
  assign bus.READY     = ready_q;
  assign bus.LOCK_LOST = lost_q;
`ifdef CCC_LOSS_COUNT_EN
  assign bus.LOSS_COUNT = loss_cnt;
`endif

endmodule
